// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
// A FIFO_DEPTH-entry byte FIFO feeds a bit-timing FSM that serialises each
// byte LSB-first, holding every bit for CLK_BY_BAUDRATE UART_CLK cycles.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1, 11 bit-times per frame).
//
// Handshake: a byte transfers on a rising UART_CLK edge where
// tx_valid && tx_ready. tx_ready depends only on the registered fifo_count,
// never on tx_valid or on a pop in the same cycle.
module uart_tx_buffered #(
  parameter int CLK_BY_BAUDRATE = 10416,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_AW         = 2
) (
  input  logic               UART_CLK,
  input  logic               reset_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam logic [13:0]      BIT_RELOAD = 14'(CLK_BY_BAUDRATE - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT  = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and pointers
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push;
  logic               pop;

  // Serialiser state; state is kept as a plainly named register for probing
  state_t      state;
  state_t      state_nxt;
  logic [13:0] bit_cnt;
  logic [13:0] cnt_nxt;
  logic [2:0]  bit_idx;
  logic [2:0]  idx_nxt;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_nxt;
  logic        tx_nxt;

  assign tx_ready = (fifo_count < DEPTH_CNT);
  assign push     = tx_valid && tx_ready;
  assign tx_busy  = (state != S_IDLE);

  // Byte storage: data is captured at push time only
  always_ff @(posedge UART_CLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge UART_CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // Serialiser registers; reset forces the line high even mid-bit
  always_ff @(posedge UART_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shift_reg <= shift_nxt;
      tx        <= tx_nxt;
    end
  end

  // Next-state logic: every bit lasts BIT_RELOAD+1 cycles, counted down to 0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift_reg;
    tx_nxt    = tx;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          cnt_nxt   = BIT_RELOAD;
          tx_nxt    = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_cnt == '0) begin
          cnt_nxt   = BIT_RELOAD;
          tx_nxt    = shift_reg[0];
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = bit_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_cnt == '0) begin
          cnt_nxt = BIT_RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt    = ^shift_reg;
            state_nxt = S_PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
`endif
          end else begin
            idx_nxt = bit_idx + 3'd1;
            tx_nxt  = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          cnt_nxt = bit_cnt - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_cnt == '0) begin
          cnt_nxt   = BIT_RELOAD;
          tx_nxt    = 1'b1;
          state_nxt = S_STOP;
        end else begin
          cnt_nxt = bit_cnt - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_cnt == '0) begin
          tx_nxt    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = bit_cnt - 1'b1;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench for uart_tx_buffered at 16 clocks/bit.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_uart_tx_buffered;

  localparam int CBB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CBB;

  // ---------------- clock / reset ----------------
  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [7:0]    tx_data  = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;
  logic [AW:0]   fifo_count;

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         gap_q[$];
  bit         ok_q[$];

  uart_tx_buffered #(
    .CLK_BY_BAUDRATE(CBB),
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW(AW)
  ) dut (
    .UART_CLK(clk),
    .reset_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Line decoder: samples tx on every falling edge, rebuilds each frame,
  // records the byte, a frame-integrity flag and the idle run before it.
  initial begin : monitor
    int   s;
    bit   in_frame;
    bit   glitch;
    logic cur;
    logic bits [FRAME_BITS];
    int   ones;
    logic [7:0] data;
    bit   ok;
    in_frame = 1'b0;
    ones     = 0;
    s        = 0;
    glitch   = 1'b0;
    cur      = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        ones     = 0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          s        = 1;
          cur      = 1'b0;
          bits[0]  = 1'b0;
          glitch   = 1'b0;
          gap_q.push_back(ones);
        end else begin
          ones++;
        end
      end else begin
        if (s % CBB == 0) begin
          cur           = tx;
          bits[s / CBB] = tx;
        end else if (tx !== cur) begin
          glitch = 1'b1;
        end
        s++;
        if (s == FRAME_CYC) begin
          for (int i = 0; i < 8; i++) data[i] = bits[1 + i];
          ok = !glitch && (bits[FRAME_BITS - 1] === 1'b1);
`ifdef UART_TX_PARITY_EN
          ok = ok && (bits[9] === ^data);
`endif
          got_q.push_back(data);
          ok_q.push_back(ok);
          in_frame = 1'b0;
          ones     = 0;
        end
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    gap_q.delete();
    ok_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, tx_ready, fifo_count, tx_busy} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: tx=%b ready=%b count=%0d busy=%b, want 1 1 0 0",
               tx, tx_ready, fifo_count, tx_busy);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, tx_ready, fifo_count, tx_busy} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL idle_cycle_%0d: tx=%b ready=%b count=%0d busy=%b, want 1 1 0 0",
                 c, tx, tx_ready, fifo_count, tx_busy);
      end
    end
  endtask

  // Cycle-exact check of one frame; line[k] is the k-th bit on the wire.
  task automatic test_single_frame(input logic [7:0] b, input logic [10:0] line,
                                   input string name);
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before_push: got %b want 1", name, tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    checks++;
    if ({tx, tx_busy, fifo_count} !== {1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL %s_after_push: tx=%b busy=%b count=%0d, want 1 0 1",
               name, tx, tx_busy, fifo_count);
    end
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      checks++;
      if ({tx, tx_busy, fifo_count} !== {line[k / CBB], 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL %s_cycle_%0d: tx=%b busy=%b count=%0d, want %b 1 0",
                 name, k, tx, tx_busy, fifo_count, line[k / CBB]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx, tx_busy} !== 2'b10) begin
      errors++;
      $display("FAIL %s_end: tx=%b busy=%b, want 1 0", name, tx, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  seq [6];
    logic [AW:0] cnt_exp [5];
    int          wait_cyc;
    int          budget;
    seq     = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55, 8'h99};
    cnt_exp = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    clear_queues();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({tx_ready, fifo_count} !== {1'b1, cnt_exp[i]}) begin
        errors++;
        $display("FAIL b2b_push_%0d: ready=%b count=%0d, want 1 %0d",
                 i, tx_ready, fifo_count, cnt_exp[i]);
      end
      tx_data  = seq[i];
      tx_valid = 1'b1;
      exp_q.push_back(seq[i]);
      @(negedge clk);
    end
    tx_data = seq[5];
    exp_q.push_back(seq[5]);
    checks++;
    if ({tx_ready, fifo_count} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL b2b_full: ready=%b count=%0d, want 0 4", tx_ready, fifo_count);
    end
    wait_cyc = 0;
    while (tx_ready !== 1'b1 && wait_cyc < 2 * FRAME_CYC) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (wait_cyc !== FRAME_CYC - 2) begin
      errors++;
      $display("FAIL b2b_sixth_wait: waited %0d cycles, want %0d", wait_cyc, FRAME_CYC - 2);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    budget = 0;
    while (got_q.size() < 6 && budget < 7 * FRAME_CYC) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (got_q.size() !== 6) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d frames, want 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || ok_q[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame_%0d: got %h ok=%b, want %h ok=1", i, got_q[i], ok_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < 6 && i < gap_q.size(); i++) begin
      checks++;
      if (gap_q[i] !== 1) begin
        errors++;
        $display("FAIL b2b_gap_%0d: got %0d idle cycles, want 1", i, gap_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    clear_queues();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_data  = 8'h11;
    @(negedge clk);
    tx_data  = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    // frame start was sampled one negedge ago; move into the middle of data bit 3
    repeat (70) @(negedge clk);
    checks++;
    if ({tx, tx_busy, fifo_count} !== {1'b0, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL midframe_before_reset: tx=%b busy=%b count=%0d, want 0 1 2",
               tx, tx_busy, fifo_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, tx_busy, fifo_count, tx_ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL midframe_async_reset: tx=%b busy=%b count=%0d ready=%b, want 1 0 0 1",
               tx, tx_busy, fifo_count, tx_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    lows = 0;
    for (int c = 0; c < 2 * FRAME_CYC; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    checks++;
    if (lows !== 0 || got_q.size() !== 0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL midframe_after_release: active cycles=%0d frames=%0d count=%0d, want 0 0 0",
               lows, got_q.size(), fifo_count);
    end
  endtask

  task automatic test_hold_full();
    logic [7:0] bytes [8];
    int  i;
    int  cyc;
    bit  acc;
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    clear_queues();
    @(negedge clk);
    i        = 0;
    cyc      = 0;
    tx_valid = 1'b1;
    tx_data  = bytes[0];
    while (i < 8 && cyc < 10 * FRAME_CYC) begin
      acc = (tx_ready === 1'b1);
      @(negedge clk);
      cyc++;
      checks++;
      if (fifo_count > 3'd4) begin
        errors++;
        $display("FAIL hold_count_bound: count=%0d, want <= 4", fifo_count);
      end
      if (acc) begin
        exp_q.push_back(bytes[i]);
        i++;
        if (i < 8) tx_data = bytes[i];
      end
    end
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    checks++;
    if (i !== 8) begin
      errors++;
      $display("FAIL hold_accepted: accepted %0d bytes, want 8", i);
    end
    cyc = 0;
    while (got_q.size() < 8 && cyc < 10 * FRAME_CYC) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got_q.size() !== 8) begin
      errors++;
      $display("FAIL hold_frame_count: got %0d frames, want 8", got_q.size());
    end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== bytes[k] || ok_q[k] !== 1'b1) begin
        errors++;
        $display("FAIL hold_frame_%0d: got %h ok=%b, want %h ok=1", k, got_q[k], ok_q[k], bytes[k]);
      end
    end
    for (int k = 1; k < 8 && k < gap_q.size(); k++) begin
      checks++;
      if (gap_q[k] !== 1) begin
        errors++;
        $display("FAIL hold_gap_%0d: got %0d idle cycles, want 1", k, gap_q[k]);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] line;
    line = {1'b1, 1'b1, 8'h07, 1'b0};
    test_single_frame(8'h07, line, "parity_07");
    line = {1'b1, 1'b0, 8'h03, 1'b0};
    test_single_frame(8'h03, line, "parity_03");
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    logic [10:0] line;
    test_reset();
`ifdef UART_TX_PARITY_EN
    line = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    line = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
    test_single_frame(8'hA5, line, "frame_a5");
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_reset_mid_frame();
    test_hold_full();
    repeat (5) @(negedge clk);
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter; the transmit-side counterpart of the on-chip UART receiver.
- Sits between the processor's memory-mapped UART peripheral register and the external tx pin.
- A small FIFO accepts bytes from the CPU through a valid/ready handshake.
- A bit-timing state machine serialises each byte LSB-first at CLK_BY_BAUDRATE UART_CLK cycles per bit.

Parameters:
- CLK_BY_BAUDRATE, 10416: UART_CLK cycles per bit; must be >= 2.
- FIFO_DEPTH, 4: FIFO entries; power of two, >= 2.
- FIFO_AW, 2: log2(FIFO_DEPTH); FIFO pointer width.

Ports:
- UART_CLK  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; 1 iff fifo_count < FIFO_DEPTH.
- tx  output  1  serial line, registered; idle level 1.
- tx_busy  output  1  1 while the FSM is not in IDLE.
- fifo_count  output  FIFO_AW+1  number of bytes queued, excluding the byte being shifted.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - tx=1, tx_busy=0, fifo_count=0, tx_ready=1.
  - FSM to IDLE; bit counter and bit index cleared; FIFO pointers cleared.
  - Contents of a frame in flight are discarded. The line returns high immediately, even mid-bit.
- Push:
  - A byte is written at any rising edge where tx_valid=1 and tx_ready=1.
  - tx_valid while full is ignored, with no overwrite and no error.
  - tx_ready is derived from the current count only. A pop in the same cycle does not enable a push while full.
- Pop:
  - Happens only in IDLE when fifo_count > 0.
  - Simultaneous push and pop leaves fifo_count unchanged; data order is preserved.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates logically at FIFO_DEPTH and never exceeds it.
- FSM states:
  - IDLE: tx=1. If FIFO is non-empty: pop into shift register, load bit counter with CLK_BY_BAUDRATE-1, drive tx=0, go to START.
  - START: when counter==0, reload the counter, drive tx=shift[0], bit index=0, go to DATA. Otherwise decrement.
  - DATA: when counter==0: if bit index==7, drive tx=1 and go to STOP; otherwise increment the index and drive tx=shift[index+1]. Reload the counter. Otherwise decrement.
  - STOP: when counter==0, go to IDLE with tx held at 1. Otherwise decrement.
- Timing:
  - Each bit (start, 8 data, stop) is held exactly CLK_BY_BAUDRATE cycles. A frame is 10*CLK_BY_BAUDRATE cycles.
  - Latency: byte accepted at edge N, FIFO previously empty and FSM in IDLE. tx falls after edge N+1.
  - Back-to-back frames: exactly one IDLE cycle (tx=1) between the end of the stop bit and the next start bit.
- tx_data is captured at push. Later changes on tx_data do not affect queued bytes.
- The counter is 14 bits wide and is sized for the CLK_BY_BAUDRATE default.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLK_BY_BAUDRATE cycles.
  - A frame is 11*CLK_BY_BAUDRATE cycles.
- When undefined: no PARITY state and no parity logic; frame is 10 bit-times (8N1).

Test Plan:
- Reset, then idle 50 cycles with CLK_BY_BAUDRATE=16 -> tx=1, tx_ready=1, fifo_count=0, tx_busy=0 throughout.
- Push 0xA5 with CLK_BY_BAUDRATE=16 -> tx falls 2 edges after push. The line then carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles. tx_busy drops after 160 cycles.
- Push 0x00, 0xFF, 0x3C, 0x81, 0x55 on consecutive cycles -> first 5 accepted (one pops at once, 4 queued). The 6th push attempt is held with tx_ready=0 until a pop. Frames emerge in order with exactly one idle cycle between them.
- Assert reset_n=0 during data bit 3 of a frame with 2 bytes queued -> tx=1 immediately (asynchronously), fifo_count=0. After release, no frame is sent.
- Push while full with tx_valid held high -> exactly one byte enters per pop. No loss or duplication across 8 bytes; checked by a decoding monitor.
- With UART_TX_PARITY_EN, push 0x07 -> parity bit 1, frame 11 bit-times. Push 0x03 -> parity bit 0.
